brownout_filt_timer: RTL and testbench
======================================

Name: brownout_filt_timer

Overview:
- Digital back end of the brownout detector, clocked directly by the RC oscillator output osc_ck (~41 MHz, period 24.39 ns).
- Synchronizes the raw undervoltage comparator output vunder and debounces it.
- Asserts a filtered brownout flag, then holds it for a programmable recovery time after the supply returns.
- Feeds the chip-level reset generator.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on vunder (min 2).
- FILT_CNT, 8, consecutive high synchronized samples required to declare brownout (1..15).
- TMR_W, 14, hold-timer width; must cover the largest tsel value.

Ports:
- osc_ck  in  1  clock, from the RC oscillator.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  block enable; level, quasi-static.
- vunder  in  1  raw comparator output, asynchronous; 1 = supply below threshold.
- tsel  in  2  hold-time select: 0=256, 1=1024, 2=4096, 3=16384 osc_ck cycles.
- brout_filt  out  1  filtered brownout, registered; 1 = hold system in reset.
- timed_out  out  1  one-cycle pulse when the hold timer expires and brout_filt falls.

Behaviour:
- Reset: one clock and reset. Reset is synchronous and active-high. While rst=1 at a posedge: state=OFF, synchronizer=0, counters=0, brout_filt=0, timed_out=0.
- vunder_s is vunder after SYNC_STAGES flops. All decisions use vunder_s only.
- FSM states: OFF, BROWNOUT, HOLD, OK, DEBOUNCE.
- Any state, ena=0: go to OFF next edge. Takes priority over all other transitions except rst.
- OFF: brout_filt=0, timers cleared. ena=1 goes to BROWNOUT (power-up behaves as a brownout).
- BROWNOUT: brout_filt=1. vunder_s=0 goes to HOLD; hold counter loads HOLD_N(tsel)-1. tsel is sampled only at this load.
- HOLD: brout_filt=1, counter decrements each cycle.
  - vunder_s=1 returns to BROWNOUT; the timer is discarded and restarts from full on the next exit.
  - At count 0 with vunder_s=0: go to OK. brout_filt=0 and timed_out=1 on that same edge, for one cycle only.
  - If vunder_s=1 in the same cycle as count 0, it goes to BROWNOUT; no timed_out pulse.
  - Result: brout_filt deasserts exactly HOLD_N cycles after HOLD entry, given uninterrupted vunder_s=0.
- OK: brout_filt=0. vunder_s=1 goes to DEBOUNCE with filter count=1.
- DEBOUNCE: brout_filt=0.
  - vunder_s=0 returns to OK and clears the count.
  - vunder_s=1 increments the count. When count=FILT_CNT, go to BROWNOUT.
  - Result: brout_filt rises on the edge that registers the FILT_CNT-th consecutive high sample.
  - Latency from a stable vunder rise: SYNC_STAGES+FILT_CNT edges (10 at defaults).
  - Glitches shorter than FILT_CNT cycles never assert brout_filt.
- FILT_CNT=1: DEBOUNCE is skipped; OK goes straight to BROWNOUT on vunder_s=1.
- Counters saturate and never wrap. Unused state encodings recover to OFF.
- rst mid-operation: outputs drop to 0 on the next edge, even from BROWNOUT. The system-level POR covers this window.

Optional Feature:
- BROWNOUT_FORCE_EN defined: adds input force_brout (1 bit).
  - While force_brout=1 and ena=1, the FSM goes to BROWNOUT on the next edge and stays there.
  - On release, the normal HOLD sequence applies.
- Undefined: no port; behaviour as above.

Decomposition:
- Shared package brownout_pkg holds:
  - state enum bo_state_t;
  - HOLD_N lookup constants for the tsel codes;
  - default FILT_CNT and TMR_W constants.
- One sub-module: bo_sync, a parameterized SYNC_STAGES flop chain with synchronous reset to 0, instantiated for vunder.

Test Plan:
- Reset then ena=1, vunder=0, tsel=0:
  - brout_filt=1 from the first edge after ena;
  - falls exactly 256 cycles after HOLD entry, with a single timed_out pulse on that edge.
- In OK, vunder high for 7 cycles then low: brout_filt stays 0. Vunder high for 8+ cycles: brout_filt rises 10 edges after the vunder rise.
- In HOLD with tsel=2, vunder pulse long enough to reach vunder_s at cycle 4000:
  - returns to BROWNOUT with no timed_out;
  - after recovery, a fresh 4096-cycle hold elapses before brout_filt falls.
- tsel changed from 3 to 0 mid-HOLD: hold length stays 16384, because tsel was latched at entry.
- ena dropped during BROWNOUT, and separately rst=1 during HOLD: brout_filt=0 and timed_out=0 on the next edge; FSM in OFF.
- With BROWNOUT_FORCE_EN, force_brout=1 for 5 cycles in OK: brout_filt=1 on the next edge; after release, HOLD_N(tsel) cycles elapse before it falls.

Source files
------------

// File: rtl/brownout_pkg.sv
// -----------------------------------------------------------------------------
// brownout_pkg
// Shared definitions for the brownout detector digital back end:
//   - bo_state_t : FSM state encoding used by brownout_filt_timer
//   - HOLD_N_*   : recovery hold lengths (osc_ck cycles) for each tsel code
//   - *_DEF      : default structural constants for the top level
//   - hold_n()   : maps a tsel code to its hold length
// -----------------------------------------------------------------------------
package brownout_pkg;

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_BROWNOUT = 3'd1,
        S_HOLD     = 3'd2,
        S_OK       = 3'd3,
        S_DEBOUNCE = 3'd4
    } bo_state_t;

    // Hold lengths selected by tsel, in osc_ck cycles.
    localparam int HOLD_N_0 = 256;
    localparam int HOLD_N_1 = 1024;
    localparam int HOLD_N_2 = 4096;
    localparam int HOLD_N_3 = 16384;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_CNT_DEF    = 8;
    localparam int TMR_W_DEF       = 14;

    // Filter counter width: wide enough for FILT_CNT up to 15.
    localparam int FILT_W = 4;

    function automatic int hold_n(input logic [1:0] sel);
        case (sel)
            2'd0:    return HOLD_N_0;
            2'd1:    return HOLD_N_1;
            2'd2:    return HOLD_N_2;
            default: return HOLD_N_3;
        endcase
    endfunction

endpackage

// File: rtl/bo_sync.sv
// -----------------------------------------------------------------------------
// bo_sync
// Multi-flop synchronizer for a single asynchronous level input.
// Ports:
//   clk  in  1  sampling clock
//   rst  in  1  synchronous reset, active-high; clears the chain to 0
//   d    in  1  asynchronous input
//   q    out 1  d after STAGES flops
// Parameter STAGES must be at least 2.
// -----------------------------------------------------------------------------
module bo_sync
    import brownout_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[STAGES-2:0], d};
        end
    end

    assign q = sync_p0[STAGES-1];

endmodule

// File: rtl/brownout_filt_timer.sv
// -----------------------------------------------------------------------------
// brownout_filt_timer
// Digital back end of the brownout detector, clocked by the RC oscillator.
// Synchronizes and debounces the undervoltage comparator, raises a filtered
// brownout flag and holds it for a programmable time after the supply returns.
//
// Ports:
//   osc_ck      in  1  clock from the RC oscillator
//   rst         in  1  synchronous reset, active-high
//   ena         in  1  block enable (quasi-static level)
//   vunder      in  1  raw comparator output, async; 1 = supply low
//   tsel        in  2  hold select: 0=256, 1=1024, 2=4096, 3=16384 cycles
//   force_brout in  1  (BROWNOUT_FORCE_EN only) force the brownout state
//   brout_filt  out 1  filtered brownout, registered; 1 = hold system in reset
//   timed_out   out 1  one-cycle pulse when the hold expires
//
// Build option: define BROWNOUT_FORCE_EN to add the force_brout input.
// -----------------------------------------------------------------------------
module brownout_filt_timer
    import brownout_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_CNT    = FILT_CNT_DEF,
    parameter int TMR_W       = TMR_W_DEF
) (
    input  logic       osc_ck,
    input  logic       rst,
    input  logic       ena,
    input  logic       vunder,
    input  logic [1:0] tsel,
`ifdef BROWNOUT_FORCE_EN
    input  logic       force_brout,
`endif
    output logic       brout_filt,
    output logic       timed_out
);

    logic              vunder_s;
    logic              force_req;
    bo_state_t         state;
    logic [TMR_W-1:0]  hold_cnt;
    logic [FILT_W-1:0] filt_cnt;

`ifdef BROWNOUT_FORCE_EN
    assign force_req = force_brout;
`else
    assign force_req = 1'b0;
`endif

    // Hold counter counts HOLD_N-1 down to 0 and expires on the following
    // edge, so brout_filt falls exactly HOLD_N edges after HOLD entry.
    function automatic logic [TMR_W-1:0] hold_load(input logic [1:0] sel);
        return TMR_W'(hold_n(sel) - 1);
    endfunction

    function automatic logic [TMR_W-1:0] hold_dec(input logic [TMR_W-1:0] c);
        return (c == '0) ? c : c - TMR_W'(1);
    endfunction

    function automatic logic [FILT_W-1:0] filt_inc(input logic [FILT_W-1:0] c);
        return (c == {FILT_W{1'b1}}) ? c : c + FILT_W'(1);
    endfunction

    // Stage p0: synchronizer on the asynchronous comparator output
    bo_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_vunder (
        .clk (osc_ck),
        .rst (rst),
        .d   (vunder),
        .q   (vunder_s)
    );

    // Stage p1: filter / hold FSM with registered outputs
    always_ff @(posedge osc_ck) begin
        if (rst) begin
            state      <= S_OFF;
            hold_cnt   <= '0;
            filt_cnt   <= '0;
            brout_filt <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            timed_out <= 1'b0;
            if (!ena) begin
                state      <= S_OFF;
                hold_cnt   <= '0;
                filt_cnt   <= '0;
                brout_filt <= 1'b0;
            end else if (force_req) begin
                state      <= S_BROWNOUT;
                hold_cnt   <= '0;
                filt_cnt   <= '0;
                brout_filt <= 1'b1;
            end else begin
                case (state)
                    S_OFF: begin
                        // Enabling behaves like a power-up brownout.
                        state      <= S_BROWNOUT;
                        hold_cnt   <= '0;
                        filt_cnt   <= '0;
                        brout_filt <= 1'b1;
                    end

                    S_BROWNOUT: begin
                        brout_filt <= 1'b1;
                        filt_cnt   <= '0;
                        if (!vunder_s) begin
                            // tsel is captured only here; later changes do
                            // not affect a hold already in progress.
                            state    <= S_HOLD;
                            hold_cnt <= hold_load(tsel);
                        end
                    end

                    S_HOLD: begin
                        if (vunder_s) begin
                            // Supply dipped again: drop the partial hold.
                            state      <= S_BROWNOUT;
                            hold_cnt   <= '0;
                            brout_filt <= 1'b1;
                        end else if (hold_cnt == '0) begin
                            state      <= S_OK;
                            brout_filt <= 1'b0;
                            timed_out  <= 1'b1;
                        end else begin
                            hold_cnt   <= hold_dec(hold_cnt);
                            brout_filt <= 1'b1;
                        end
                    end

                    S_OK: begin
                        brout_filt <= 1'b0;
                        hold_cnt   <= '0;
                        if (vunder_s) begin
                            if (FILT_CNT <= 1) begin
                                state      <= S_BROWNOUT;
                                filt_cnt   <= '0;
                                brout_filt <= 1'b1;
                            end else begin
                                state    <= S_DEBOUNCE;
                                filt_cnt <= FILT_W'(1);
                            end
                        end else begin
                            filt_cnt <= '0;
                        end
                    end

                    S_DEBOUNCE: begin
                        brout_filt <= 1'b0;
                        if (!vunder_s) begin
                            state    <= S_OK;
                            filt_cnt <= '0;
                        end else if (filt_inc(filt_cnt) >= FILT_W'(FILT_CNT)) begin
                            // This edge registers the FILT_CNT-th high sample.
                            state      <= S_BROWNOUT;
                            filt_cnt   <= '0;
                            brout_filt <= 1'b1;
                        end else begin
                            filt_cnt <= filt_inc(filt_cnt);
                        end
                    end

                    default: begin
                        state      <= S_OFF;
                        hold_cnt   <= '0;
                        filt_cnt   <= '0;
                        brout_filt <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_brownout_filt_timer.sv
`timescale 1ns/1ps
module tb_brownout_filt_timer;

    logic       osc_ck = 1'b0;
    logic       rst    = 1'b1;
    logic       ena    = 1'b0;
    logic       vunder = 1'b0;
    logic [1:0] tsel   = 2'd0;
`ifdef BROWNOUT_FORCE_EN
    logic       force_brout = 1'b0;
    localparam int EXP_PULSES = 5;
`else
    localparam int EXP_PULSES = 4;
`endif
    logic       brout_filt;
    logic       timed_out;

    int vectors = 0;
    int errors  = 0;
    int pulses  = 0;

    brownout_filt_timer dut (
        .osc_ck      (osc_ck),
        .rst         (rst),
        .ena         (ena),
        .vunder      (vunder),
        .tsel        (tsel),
`ifdef BROWNOUT_FORCE_EN
        .force_brout (force_brout),
`endif
        .brout_filt  (brout_filt),
        .timed_out   (timed_out)
    );

    initial begin
        forever #12.195 osc_ck = ~osc_ck;
    end

    // Advance n edges; observe 1 ns after each edge and tally timed_out pulses.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge osc_ck);
            #1;
            if (timed_out === 1'b1) pulses++;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        tick(3);
        chk("rst_brout", brout_filt, 1'b0);
        chk("rst_to", timed_out, 1'b0);
        rst = 1'b0;
        tick(2);
        chk("off_brout", brout_filt, 1'b0);

        // Enable: power-up brownout, then 256-cycle hold with tsel=0
        ena = 1'b1;
        tick(1);
        chk("ena_brout", brout_filt, 1'b1);
        tick(256);
        chk("hold256_last", brout_filt, 1'b1);
        chk("hold256_no_to", timed_out, 1'b0);
        tick(1);
        chk("hold256_fall", brout_filt, 1'b0);
        chk("hold256_to", timed_out, 1'b1);
        tick(1);
        chk("to_one_cycle", timed_out, 1'b0);
        chk_int("pulses_1", pulses, 1);

        // 7-cycle glitch in OK must not assert brout_filt
        vunder = 1'b1;
        tick(7);
        vunder = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("glitch7", brout_filt, 1'b0);
        end

        // Stable rise: brout_filt rises on the 10th edge
        vunder = 1'b1;
        tick(9);
        chk("rise_edge9", brout_filt, 1'b0);
        tick(1);
        chk("rise_edge10", brout_filt, 1'b1);

        // tsel=2 hold interrupted at cycle 4000, then a fresh 4096 hold
        tsel   = 2'd2;
        vunder = 1'b0;
        tick(3);
        chk("hold4k_entry", brout_filt, 1'b1);
        tick(3997);
        vunder = 1'b1;
        tick(1);
        vunder = 1'b0;
        tick(2);
        chk("hold4k_interrupt", brout_filt, 1'b1);
        chk("hold4k_int_no_to", timed_out, 1'b0);
        tick(1);
        tick(4095);
        chk("hold4k_fresh_last", brout_filt, 1'b1);
        chk_int("pulses_none_4k", pulses, 1);
        tick(1);
        chk("hold4k_fall", brout_filt, 1'b0);
        chk("hold4k_to", timed_out, 1'b1);
        chk_int("pulses_2", pulses, 2);

        // tsel latched at HOLD entry: 3 -> 0 mid-hold keeps 16384
        vunder = 1'b1;
        tick(12);
        chk("bo_for_16k", brout_filt, 1'b1);
        tsel   = 2'd3;
        vunder = 1'b0;
        tick(3);
        tsel = 2'd0;
        tick(256);
        chk("hold16k_at256", brout_filt, 1'b1);
        tick(16127);
        chk("hold16k_last", brout_filt, 1'b1);
        tick(1);
        chk("hold16k_fall", brout_filt, 1'b0);
        chk("hold16k_to", timed_out, 1'b1);

        // ena dropped during BROWNOUT
        vunder = 1'b1;
        tick(12);
        chk("bo_before_ena0", brout_filt, 1'b1);
        ena = 1'b0;
        tick(1);
        chk("ena0_brout", brout_filt, 1'b0);
        chk("ena0_to", timed_out, 1'b0);
        tick(2);
        chk("ena0_stay", brout_filt, 1'b0);
        ena    = 1'b1;
        vunder = 1'b0;
        tick(1);
        chk("reena_brout", brout_filt, 1'b1);

        // rst during HOLD
        tick(12);
        chk("in_hold", brout_filt, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("rst_hold_brout", brout_filt, 1'b0);
        chk("rst_hold_to", timed_out, 1'b0);
        rst = 1'b0;
        tick(1);
        chk("post_rst_brout", brout_filt, 1'b1);
        tick(1);
        tick(255);
        chk("post_rst_last", brout_filt, 1'b1);
        tick(1);
        chk("post_rst_fall", brout_filt, 1'b0);
        chk("post_rst_to", timed_out, 1'b1);
        chk_int("pulses_4", pulses, 4);

`ifdef BROWNOUT_FORCE_EN
        // Forced brownout from OK for 5 cycles, then normal 256 hold
        tick(3);
        force_brout = 1'b1;
        tick(1);
        chk("force_brout", brout_filt, 1'b1);
        tick(4);
        chk("force_stay", brout_filt, 1'b1);
        force_brout = 1'b0;
        tick(1);
        tick(255);
        chk("force_hold_last", brout_filt, 1'b1);
        tick(1);
        chk("force_hold_fall", brout_filt, 1'b0);
        chk("force_hold_to", timed_out, 1'b1);
`endif

        tick(2);
        chk("final_to", timed_out, 1'b0);
        chk_int("pulses_total", pulses, EXP_PULSES);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
